hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/rv32_hazard_pkg.sv | 37 +++
 rtl/hz_slot.sv | 38 +++
 rtl/hazard_fwd_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_hazard_pkg.sv
// ---------------------------------------------------------------------------
// rv32_hazard_pkg
// Shared definitions for the hazard / forwarding controller:
//   - EX operand mux select encodings (FWD_RF, FWD_WB, FWD_MEM)
//   - hz_slot_t: the per-stage instruction record tracked in EX, MEM and WB
//   - rd_match / src_hit: "this slot writes register r" helpers
// Register fields are HZ_AW_MAX bits wide so one record layout serves any
// REG_AW up to HZ_AW_MAX; narrower addresses are zero-extended on entry.
// ---------------------------------------------------------------------------
package rv32_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int HZ_AW_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [HZ_AW_MAX-1:0] rs1;
        logic [HZ_AW_MAX-1:0] rs2;
        logic [HZ_AW_MAX-1:0] rd;
        logic                 reg_write;
        logic                 is_load;
    } hz_slot_t;

    // True when slot s will write register r; x0 never counts as written.
    function automatic logic rd_match(hz_slot_t s, logic [HZ_AW_MAX-1:0] r);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
    endfunction

    function automatic logic src_hit(hz_slot_t s, logic [HZ_AW_MAX-1:0] a,
                                     logic [HZ_AW_MAX-1:0] b);
        return rd_match(s, a) || rd_match(s, b);
    endfunction

endpackage

// File: rtl/hz_slot.sv
// ---------------------------------------------------------------------------
// hz_slot
// One pipeline-stage record register. Asynchronous active-high reset and a
// bubble input both load an all-zero (invalid) record.
// Ports:
//   clk, rst   - clock, async active-high reset
//   bubble_i   - load an empty record instead of d_i
//   d_i        - record entering the stage
//   q_o        - record currently held by the stage
// ---------------------------------------------------------------------------
module hz_slot
    import rv32_hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     bubble_i,
    input  hz_slot_t d_i,
    output hz_slot_t q_o
);

    hz_slot_t slot_q;
    hz_slot_t slot_d;

    always_comb begin
        slot_d = bubble_i ? '0 : d_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks the instructions in EX, MEM and WB (three hz_slot instances) and
// derives, combinationally from those slots and the ID instruction:
//   fwd_a_sel / fwd_b_sel : EX operand source (00 regfile, 01 WB, 10 MEM)
//   stall_f / stall_d     : hold PC and IF/ID
//   flush_d / flush_e     : bubble IF/ID and ID/EX
//   stall_cnt             : free-running count of stall cycles (wraps)
// Inputs: clk, rst (async, active high), id_valid, id_reg_write, id_is_load,
//         id_rs1, id_rs2, id_rd, ex_branch_taken.
// Build option: define HAZARD_FWD_EN to enable forwarding with load-use
// stalls only. Without it the selects stay 00 and any RAW against EX, MEM
// or WB stalls ID until the writer has left WB.
// A taken branch always wins: it flushes ID and EX and suppresses stalls.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
    import rv32_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_slot_t         id_rec;
    hz_slot_t         ex_q;
    hz_slot_t         mem_q;
    hz_slot_t         wb_q;
    logic             ex_bubble;
    logic             hazard;
    logic             stall_raw;
    logic             flush_e_raw;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             unused_wb_bits;

    always_comb begin
        id_rec           = '0;
        id_rec.valid     = id_valid;
        id_rec.rs1       = HZ_AW_MAX'(id_rs1);
        id_rec.rs2       = HZ_AW_MAX'(id_rs2);
        id_rec.rd        = HZ_AW_MAX'(id_rd);
        id_rec.reg_write = id_reg_write;
        id_rec.is_load   = id_is_load;
    end

    // EX takes a bubble whenever ID/EX is flushed (stall or branch).
    assign ex_bubble = !id_valid || flush_e_raw;

    hz_slot u_ex_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (ex_bubble),
        .d_i      (id_rec),
        .q_o      (ex_q)
    );

    hz_slot u_mem_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    hz_slot u_wb_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    // Source fields of the WB record are never consulted.
    assign unused_wb_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.is_load};

    always_comb begin
        fwd_a_raw = FWD_RF;
        fwd_b_raw = FWD_RF;
        hazard    = 1'b0;
`ifdef HAZARD_FWD_EN
        // MEM holds the younger result, so it is checked first.
        if (rd_match(mem_q, ex_q.rs1)) begin
            fwd_a_raw = FWD_MEM;
        end else if (rd_match(wb_q, ex_q.rs1)) begin
            fwd_a_raw = FWD_WB;
        end
        if (rd_match(mem_q, ex_q.rs2)) begin
            fwd_b_raw = FWD_MEM;
        end else if (rd_match(wb_q, ex_q.rs2)) begin
            fwd_b_raw = FWD_WB;
        end
        // Load data is not available until MEM ends: one bubble needed.
        hazard = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rec.rs1) || (ex_q.rd == id_rec.rs2));
`else
        hazard = id_valid && (src_hit(ex_q,  id_rec.rs1, id_rec.rs2) ||
                              src_hit(mem_q, id_rec.rs1, id_rec.rs2) ||
                              src_hit(wb_q,  id_rec.rs1, id_rec.rs2));
`endif
    end

    assign stall_raw   = hazard && !ex_branch_taken;
    assign flush_e_raw = stall_raw || ex_branch_taken;

    always_comb begin
        stall_cnt_d = stall_raw ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // rst masks the control outputs directly so a branch input cannot leak
    // through while the pipeline is held in reset.
    assign fwd_a_sel = fwd_a_raw;
    assign fwd_b_sel = fwd_b_raw;
    assign stall_f   = stall_raw && !rst;
    assign stall_d   = stall_raw && !rst;
    assign flush_d   = ex_branch_taken && !rst;
    assign flush_e   = flush_e_raw && !rst;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_reg_write;
    logic        id_is_load;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_branch_taken;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .flush_e         (flush_e),
        .stall_cnt       (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // hist holds one entry per cycle: the instruction that occupied EX in
    // that cycle. MEM and WB are simply the EX occupants one and two cycles
    // earlier.
    typedef struct {
        bit v;
        bit rw;
        bit ld;
        int rs1;
        int rs2;
        int rd;
    } ins_t;

    ins_t hist[$];
    ins_t m_ex, m_mem, m_wb, m_nx;
    int   m_cnt, m_fa, m_fb;
    bit   m_haz, m_stall, m_fe, m_fd;

    function automatic ins_t mk(bit v, bit rw, bit ld, int rs1, int rs2, int rd);
        ins_t t;
        t.v = v; t.rw = rw; t.ld = ld; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        return t;
    endfunction

    function automatic bit writes(ins_t s, int r);
        return s.v && s.rw && (s.rd != 0) && (s.rd == r);
    endfunction

    function automatic int fwd_of(ins_t mem, ins_t wb, int r);
        if (writes(mem, r)) return 2;
        if (writes(wb, r)) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hist.delete();
            repeat (3) hist.push_back(mk(0, 0, 0, 0, 0, 0));
            m_cnt = 0;
            m_fa = 0; m_fb = 0; m_stall = 0; m_fe = 0; m_fd = 0;
        end else begin
            m_ex  = hist[hist.size()-1];
            m_mem = hist[hist.size()-2];
            m_wb  = hist[hist.size()-3];
`ifdef HAZARD_FWD_EN
            m_fa  = fwd_of(m_mem, m_wb, m_ex.rs1);
            m_fb  = fwd_of(m_mem, m_wb, m_ex.rs2);
            m_haz = id_valid && m_ex.v && m_ex.ld && (m_ex.rd != 0) &&
                    ((m_ex.rd == int'(id_rs1)) || (m_ex.rd == int'(id_rs2)));
`else
            m_fa  = 0;
            m_fb  = 0;
            m_haz = 0;
            for (int k = 1; k <= 3; k++) begin
                if (id_valid && (writes(hist[hist.size()-k], int'(id_rs1)) ||
                                 writes(hist[hist.size()-k], int'(id_rs2))))
                    m_haz = 1;
            end
`endif
            m_stall = m_haz && !ex_branch_taken;
            m_fd    = ex_branch_taken;
            m_fe    = m_stall || ex_branch_taken;
        end
        chk("m_fwd_a",   32'(fwd_a_sel), 32'(m_fa));
        chk("m_fwd_b",   32'(fwd_b_sel), 32'(m_fb));
        chk("m_stall_f", 32'(stall_f),   32'(m_stall));
        chk("m_stall_d", 32'(stall_d),   32'(m_stall));
        chk("m_flush_d", 32'(flush_d),   32'(m_fd));
        chk("m_flush_e", 32'(flush_e),   32'(m_fe));
        chk("m_cnt",     stall_cnt,      32'(m_cnt));
        if (!rst) begin
            if (m_stall) m_cnt++;
            m_nx = mk(0, 0, 0, 0, 0, 0);
            if (id_valid && !m_fe)
                m_nx = mk(1, id_reg_write, id_is_load, int'(id_rs1), int'(id_rs2), int'(id_rd));
            hist.push_back(m_nx);
            void'(hist.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit rw, input bit ld,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit br);
        @(posedge clk);
        #1;
        id_valid = v; id_reg_write = rw; id_is_load = ld;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hand-computed expectation for the current cycle, sampled mid-cycle.
    task automatic expect_out(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                              input logic sd, input logic fe, input logic fd,
                              input logic [31:0] cnt);
        #2;
        chk({tag, ".fwd_a"},   32'(fwd_a_sel), 32'(fa));
        chk({tag, ".fwd_b"},   32'(fwd_b_sel), 32'(fb));
        chk({tag, ".stall_f"}, 32'(stall_f),   32'(sd));
        chk({tag, ".stall_d"}, 32'(stall_d),   32'(sd));
        chk({tag, ".flush_e"}, 32'(flush_e),   32'(fe));
        chk({tag, ".flush_d"}, 32'(flush_d),   32'(fd));
        chk({tag, ".cnt"},     stall_cnt,      cnt);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        id_valid = 0; id_reg_write = 0; id_is_load = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        ex_branch_taken = 1'b1;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_branch_taken = 1'b0;

`ifdef HAZARD_FWD_EN
        // lw x7 ; add x8,x7,x7
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("lu_stall", 0, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("lu_release", 0, 0, 0, 0, 0, 1);
        nop();
        expect_out("lu_fwd", 1, 1, 0, 0, 0, 1);
        // add x5 ; add x6,x5,x1
        nop(); nop();
        drive(1, 1, 0, 1, 2, 5, 0);
        drive(1, 1, 0, 5, 1, 6, 0);
        expect_out("raw1_id", 0, 0, 0, 0, 0, 1);
        nop();
        expect_out("raw1_mem", 2, 0, 0, 0, 0, 1);
        // writer x5, unrelated, reader x5
        nop(); nop();
        drive(1, 1, 0, 1, 2, 5, 0);
        drive(1, 1, 0, 3, 4, 9, 0);
        drive(1, 1, 0, 5, 0, 10, 0);
        nop();
        expect_out("raw2_wb", 1, 0, 0, 0, 0, 1);
        // two writers of x5: MEM beats WB
        drive(1, 1, 0, 1, 2, 5, 0);
        drive(1, 1, 0, 3, 3, 5, 0);
        drive(1, 1, 0, 5, 5, 11, 0);
        nop();
        expect_out("mem_wins", 2, 2, 0, 0, 0, 1);
        // x0 is never forwarded, never stalls
        nop(); nop();
        drive(1, 1, 0, 1, 2, 0, 0);
        drive(1, 1, 0, 0, 0, 12, 0);
        expect_out("x0_id", 0, 0, 0, 0, 0, 1);
        nop();
        expect_out("x0_fwd", 0, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 13, 0);
        expect_out("x0_lu", 0, 0, 0, 0, 0, 1);
        // load-use coincident with a taken branch
        nop(); nop();
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 14, 1);
        expect_out("lu_br", 0, 0, 0, 1, 1, 1);
        nop();
        expect_out("after_br", 0, 0, 0, 0, 0, 1);
        // reset during a load-use stall
        nop(); nop();
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 15, 0);
        expect_out("rst_pre", 0, 0, 1, 1, 0, 1);
`else
        // lw x7 ; add x8,x7,x7 : stall while x7 sits in EX, MEM, WB
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("nf_lu_ex", 0, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("nf_lu_mem", 0, 0, 1, 1, 0, 1);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("nf_lu_wb", 0, 0, 1, 1, 0, 2);
        drive(1, 1, 0, 7, 7, 8, 0);
        expect_out("nf_lu_go", 0, 0, 0, 0, 0, 3);
        nop();
        expect_out("nf_lu_after", 0, 0, 0, 0, 0, 3);
        // writer x5, unrelated, reader x5 : RAW at distance 2
        nop(); nop();
        drive(1, 1, 0, 1, 2, 5, 0);
        drive(1, 1, 0, 3, 4, 9, 0);
        drive(1, 1, 0, 5, 0, 10, 0);
        expect_out("nf_d2_mem", 0, 0, 1, 1, 0, 3);
        drive(1, 1, 0, 5, 0, 10, 0);
        expect_out("nf_d2_wb", 0, 0, 1, 1, 0, 4);
        drive(1, 1, 0, 5, 0, 10, 0);
        expect_out("nf_d2_go", 0, 0, 0, 0, 0, 5);
        // x0 never stalls
        nop(); nop();
        drive(1, 1, 0, 1, 2, 0, 0);
        drive(1, 1, 0, 0, 0, 12, 0);
        expect_out("nf_x0", 0, 0, 0, 0, 0, 5);
        drive(1, 1, 0, 0, 0, 13, 0);
        expect_out("nf_x0_mem", 0, 0, 0, 0, 0, 5);
        // RAW coincident with a taken branch
        nop(); nop(); nop();
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 14, 1);
        expect_out("nf_lu_br", 0, 0, 0, 1, 1, 5);
        nop();
        expect_out("nf_after_br", 0, 0, 0, 0, 0, 5);
        // reset during a stall
        nop(); nop(); nop();
        drive(1, 1, 1, 1, 0, 7, 0);
        drive(1, 1, 0, 7, 7, 15, 0);
        expect_out("nf_rst_pre", 0, 0, 1, 1, 0, 5);
`endif
        rst = 1'b1;
        #1;
        expect_out("rst_async", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("no_replay", 0, 0, 0, 0, 0, 0);
        nop(); nop(); nop();
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
